// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port unified memory between the
// instruction-fetch path and the load/store path of a multi-cycle core.
// Round-robin on ties, fixed-latency access sequencing, one-cycle ack pulses.
module mem_port_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic       last_grant;  // 1 = data port was granted last, 0 = fetch
  logic       grant_d;     // port owning the access in flight
  logic [2:0] count;       // remaining ACCESS cycles after the current one
  logic       pick_d;

  // Data wins when it is alone, or on a tie when fetch was served last.
  always_comb begin
    pick_d = d_req & (~if_req | ~last_grant);
  end

  // The core is stalled while any request has not yet been acknowledged.
  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Arbitration FSM; all memory-side and ack outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      grant_d    <= 1'b0;
      count      <= 3'd0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req | d_req) begin
            state      <= ACCESS;
            count      <= 3'(MEM_LAT - 1);
            mem_en     <= 1'b1;
            grant_d    <= pick_d;
            last_grant <= pick_d;
            if (pick_d) begin
              mem_we    <= d_we;
              mem_byte  <= d_byte;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              // Fetches are always full-word reads.
              mem_we    <= 1'b0;
              mem_byte  <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (count == 3'd0) begin
            state     <= DONE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (grant_d) begin
              d_ack <= 1'b1;
              if (mem_we)
                d_rdata <= '0;
              else if (mem_byte)
                d_rdata <= {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
              else
                d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            count <= count - 3'd1;
          end
        end
        DONE: begin
          // Requests are not sampled here, so a held req re-arbitrates in IDLE.
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path and the load/store data path of the multi-cycle MIPS core.
- Arbitrates between the two requesters and sequences each access with a fixed memory latency.
- Returns read data with a one-cycle ack pulse; drives the core's stall line while any request is outstanding.

Parameters:
- ADDR_W, 18, memory byte-address width (matches the data-memory address slice).
- DATA_W, 32, word width.
- MEM_LAT, 2, memory access cycles; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  instruction fetch request; held until if_ack.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_ack  output  1  one-cycle pulse; fetch complete.
- if_rdata  output  DATA_W  fetched instruction; valid while if_ack is high.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_byte  input  1  byte access (lb/sb) when 1.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle pulse; data access complete.
- d_rdata  output  DATA_W  load data; valid while d_ack is high.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_byte  output  1  byte-lane select to memory.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid on the last ACCESS cycle.
- stall  output  1  combinational: (if_req & ~if_ack) | (d_req & ~d_ack).

Behaviour:
- Reset values (asynchronous): state=IDLE, last_grant=IF, count=0. if_ack, d_ack, mem_en, mem_we and mem_byte are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, no request pending: all memory outputs stay 0.
- IDLE, exactly one request pending: grant it.
- IDLE, both requests pending: grant the requester that is not last_grant (round-robin). The first tie after reset therefore goes to data.
- On grant: latch addr, we, byte and wdata into mem_* registers; update last_grant; set count=MEM_LAT-1; go to ACCESS.
- A fetch grant forces mem_we=0 and mem_byte=0.
- ACCESS:
  - mem_en=1; mem_we, mem_byte, mem_addr and mem_wdata are held constant for exactly MEM_LAT cycles.
  - Decrement count each cycle.
  - When count==0: register mem_rdata into the granted rdata output, then go to DONE.
- DONE:
  - Pulse the granted ack for exactly one cycle; all memory outputs are 0.
  - Requests are ignored in DONE; return to IDLE next cycle.
- Latency: request seen in IDLE at cycle T; memory active T+1..T+MEM_LAT; ack at T+MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Byte load: d_rdata = {24'b0, mem_rdata[7:0]}.
- Store: d_rdata = 0 on ack.
- rdata outputs are held until the next ack of the same port.
- Requester drops req before ack: the latched access still completes and ack still pulses. Memory outputs never change mid-access.
- req still high in the IDLE cycle after its ack: treated as a new request.
- reset asserted mid-ACCESS: mem_en and mem_we drop immediately; access aborted; no ack issued.
- Only one ack may be high in any cycle; if_ack and d_ack are never both 1.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, stall=0.
- Single fetch, if_addr=0x10, MEM_LAT=2, memory returns 0x8C010004 -> mem_en high 2 cycles with mem_addr=0x10 and mem_we=0; if_ack pulse at T+3 with if_rdata=0x8C010004.
- Simultaneous if_req and d_req (load, d_addr=0x40) right after reset -> data granted first, d_ack at T+3; fetch granted in the following IDLE cycle, if_ack at T+7; stall high until each ack.
- Both requesters hold req continuously for 4 accesses -> grants alternate D, IF, D, IF; no ack overlap.
- Store byte: d_we=1, d_byte=1, d_addr=0x41, d_wdata=0x000000AB -> mem_we=1 and mem_byte=1 for MEM_LAT cycles; d_ack with d_rdata=0. Byte load from 0x41 with memory returning 0xFFFFFFAB -> d_rdata=0x000000AB.
- Assert reset during the first ACCESS cycle of a store -> mem_we and mem_en are 0 in the same cycle; no d_ack; after release, a re-presented d_req completes normally.
